// File: rtl/symm_pkg.sv
// symm_pkg: shared types and constants for the symmetric-decorrelation
// convergence checker (Q13 fixed-point data path, iteration counter width,
// scan FSM states and a saturating counter helper).
package symm_pkg;

    localparam int DATA_W    = 26;
    localparam int FRAC_BITS = 13;
    localparam int ITER_W    = 8;
    localparam int N_ELEM    = 16;

    // Unity in Q13 (1 << FRAC_BITS = 8192).
    localparam logic signed [DATA_W-1:0] Q13_ONE = 26'sd8192;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2
    } state_t;

    // Increment a counter, holding it at lim once lim has been reached.
    function automatic logic [ITER_W-1:0] sat_inc(
        input logic [ITER_W-1:0] cnt,
        input logic [ITER_W-1:0] lim
    );
        logic [ITER_W-1:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/symm_max_cmp.sv
// symm_max_cmp: combinational signed compare-and-select of one deviation
// element against the running maximum. take is set only on a strict
// improvement, so the first occurrence of a tied maximum is kept.
module symm_max_cmp
    import symm_pkg::*;
(
    input  logic signed [DATA_W-1:0] elem,
    input  logic signed [DATA_W-1:0] run_max,
    output logic signed [DATA_W-1:0] new_max,
    output logic                     take
);

    // Select the larger of the element and the running maximum.
    always_comb begin
        take    = 1'b0;
        new_max = run_max;
        if (elem > run_max) begin
            take    = 1'b1;
            new_max = elem;
        end else begin
            take    = 1'b0;
            new_max = run_max;
        end
    end

endmodule

// File: rtl/symm_conv_check.sv
// symm_conv_check: FastICA symmetric-decorrelation convergence detector.
// Snapshots 16 Q13 deviation magnitudes, scans them one per cycle for the
// signed maximum (floor 0), compares against TOL, and keeps sticky
// converged / timeout flags plus a saturating iteration count.
// Optional feature macro: SYMM_CONV_ARGMAX_EN adds the max_idx output.
module symm_conv_check
    import symm_pkg::*;
#(
    parameter logic signed [25:0] TOL      = 26'sd8,
    parameter int                 MAX_ITER = 100
) (
    input  logic                     clk_conv,
    input  logic                     rstn_conv,
    input  logic                     start_conv,
    input  logic                     clr_conv,
    input  logic signed [DATA_W-1:0] d11,
    input  logic signed [DATA_W-1:0] d12,
    input  logic signed [DATA_W-1:0] d13,
    input  logic signed [DATA_W-1:0] d14,
    input  logic signed [DATA_W-1:0] d21,
    input  logic signed [DATA_W-1:0] d22,
    input  logic signed [DATA_W-1:0] d23,
    input  logic signed [DATA_W-1:0] d24,
    input  logic signed [DATA_W-1:0] d31,
    input  logic signed [DATA_W-1:0] d32,
    input  logic signed [DATA_W-1:0] d33,
    input  logic signed [DATA_W-1:0] d34,
    input  logic signed [DATA_W-1:0] d41,
    input  logic signed [DATA_W-1:0] d42,
    input  logic signed [DATA_W-1:0] d43,
    input  logic signed [DATA_W-1:0] d44,
    output logic                     busy_conv,
    output logic                     done_conv,
    output logic signed [DATA_W-1:0] max_dev,
    output logic                     converged,
    output logic                     timeout,
    output logic [ITER_W-1:0]        iter_cnt
`ifdef SYMM_CONV_ARGMAX_EN
    ,
    output logic [3:0]               max_idx
`endif
);

    localparam logic [ITER_W-1:0] MAX_ITER_C  = ITER_W'(MAX_ITER);
    localparam logic [ITER_W:0]   MAX_ITER_W1 = (ITER_W+1)'(MAX_ITER);

    state_t                     state_r;
    logic signed [DATA_W-1:0]   snap_r [N_ELEM];
    logic signed [DATA_W-1:0]   d_vec_s [N_ELEM];
    logic signed [DATA_W-1:0]   run_max_r;
    logic [3:0]                 idx_r;
    logic                       busy_r;
    logic                       done_r;
    logic signed [DATA_W-1:0]   max_dev_r;
    logic                       conv_r;
    logic                       tout_r;
    logic [ITER_W-1:0]          iter_r;

    logic signed [DATA_W-1:0]   cur_elem_s;
    logic signed [DATA_W-1:0]   new_max_s;
    logic                       take_s;
    logic [ITER_W:0]            iter_plus_s;
    logic                       hit_limit_s;
    logic                       within_tol_s;
    logic [ITER_W-1:0]          iter_next_s;

    // Row-major view of the incoming deviation matrix.
    assign d_vec_s = '{d11, d12, d13, d14,
                       d21, d22, d23, d24,
                       d31, d32, d33, d34,
                       d41, d42, d43, d44};

    // Element currently under scan.
    assign cur_elem_s = snap_r[idx_r];

    symm_max_cmp u_max_cmp (
        .elem    (cur_elem_s),
        .run_max (run_max_r),
        .new_max (new_max_s),
        .take    (take_s)
    );

    // Decision terms evaluated while in DECIDE.
    always_comb begin
        iter_plus_s  = {1'b0, iter_r} + 9'd1;
        hit_limit_s  = (iter_plus_s >= MAX_ITER_W1);
        within_tol_s = (run_max_r <= TOL);
        iter_next_s  = sat_inc(iter_r, MAX_ITER_C);
    end

    // Scan FSM: snapshot on start, serial max search, then register results.
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            state_r   <= IDLE;
            run_max_r <= 26'sd0;
            idx_r     <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            max_dev_r <= 26'sd0;
            conv_r    <= 1'b0;
            tout_r    <= 1'b0;
            iter_r    <= 8'd0;
            for (int i = 0; i < N_ELEM; i++) begin
                snap_r[i] <= 26'sd0;
            end
        end else if (clr_conv) begin
            // Abort any scan; max_dev keeps the last completed result.
            state_r <= IDLE;
            idx_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            conv_r  <= 1'b0;
            tout_r  <= 1'b0;
            iter_r  <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_conv) begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            snap_r[i] <= d_vec_s[i];
                        end
                        run_max_r <= 26'sd0;
                        idx_r     <= 4'd0;
                        busy_r    <= 1'b1;
                        state_r   <= SCAN;
                    end
                end
                SCAN: begin
                    if (take_s) begin
                        run_max_r <= new_max_s;
                    end
                    idx_r <= idx_r + 4'd1;
                    if (idx_r == 4'd15) begin
                        state_r <= DECIDE;
                    end
                end
                DECIDE: begin
                    max_dev_r <= run_max_r;
                    conv_r    <= conv_r | within_tol_s;
                    // Once converged, a later check cannot raise timeout.
                    tout_r    <= tout_r | (~conv_r & hit_limit_s & ~within_tol_s);
                    iter_r    <= iter_next_s;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef SYMM_CONV_ARGMAX_EN
    logic [3:0] arg_run_r;
    logic [3:0] max_idx_r;

    // Track the index of the first strict maximum and publish it in DECIDE.
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            arg_run_r <= 4'd0;
            max_idx_r <= 4'd0;
        end else if (clr_conv) begin
            arg_run_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_conv) begin
                        arg_run_r <= 4'd0;
                    end
                end
                SCAN: begin
                    if (take_s) begin
                        arg_run_r <= idx_r;
                    end
                end
                DECIDE: begin
                    max_idx_r <= arg_run_r;
                end
                default: begin
                    arg_run_r <= 4'd0;
                end
            endcase
        end
    end

    assign max_idx = max_idx_r;
`endif

    assign busy_conv = busy_r;
    assign done_conv = done_r;
    assign max_dev   = max_dev_r;
    assign converged = conv_r;
    assign timeout   = tout_r;
    assign iter_cnt  = iter_r;

endmodule

// File: tb/tb_symm_conv_check.sv
// Self-checking bench for symm_conv_check: randomized and directed checks
// against a behavioural model (plain max search over the 16 inputs).
module tb_symm_conv_check;

    localparam int TB_MAX_ITER = 4;
    localparam int TB_TOL      = 8;

    logic               clk_conv = 1'b0;
    logic               rstn_conv;
    logic               start_conv;
    logic               clr_conv;
    logic signed [25:0] d_arr [16];
    logic               busy_conv;
    logic               done_conv;
    logic signed [25:0] max_dev;
    logic               converged;
    logic               timeout;
    logic [7:0]         iter_cnt;
`ifdef SYMM_CONV_ARGMAX_EN
    logic [3:0]         max_idx;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_iter = 0;
    bit m_conv = 0;
    bit m_tout = 0;
    int m_max  = 0;
    int m_idx  = 0;

    symm_conv_check #(.TOL(26'sd8), .MAX_ITER(TB_MAX_ITER)) dut (
        .clk_conv   (clk_conv),
        .rstn_conv  (rstn_conv),
        .start_conv (start_conv),
        .clr_conv   (clr_conv),
        .d11(d_arr[0]),  .d12(d_arr[1]),  .d13(d_arr[2]),  .d14(d_arr[3]),
        .d21(d_arr[4]),  .d22(d_arr[5]),  .d23(d_arr[6]),  .d24(d_arr[7]),
        .d31(d_arr[8]),  .d32(d_arr[9]),  .d33(d_arr[10]), .d34(d_arr[11]),
        .d41(d_arr[12]), .d42(d_arr[13]), .d43(d_arr[14]), .d44(d_arr[15]),
        .busy_conv  (busy_conv),
        .done_conv  (done_conv),
        .max_dev    (max_dev),
        .converged  (converged),
        .timeout    (timeout),
        .iter_cnt   (iter_cnt)
`ifdef SYMM_CONV_ARGMAX_EN
        ,
        .max_idx    (max_idx)
`endif
    );

    always #5 clk_conv = ~clk_conv;

    task automatic fill_all(input int v);
        for (int i = 0; i < 16; i++) d_arr[i] = 26'(v);
    endtask

    task automatic scramble();
        for (int i = 0; i < 16; i++) d_arr[i] = 26'($urandom);
    endtask

    // Reference: first strict maximum, starting from 0 at index 0.
    task automatic model_max(output int mx, output int mi);
        mx = 0;
        mi = 0;
        for (int i = 0; i < 16; i++) begin
            if (int'(d_arr[i]) > mx) begin
                mx = int'(d_arr[i]);
                mi = i;
            end
        end
    endtask

    task automatic model_clear();
        m_iter = 0;
        m_conv = 0;
        m_tout = 0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        if (max_dev !== 26'(m_max)) begin
            errors++;
            $display("FAIL %s max_dev got %0d exp %0d", tag, max_dev, m_max);
        end
        checks++;
        if (converged !== m_conv) begin
            errors++;
            $display("FAIL %s converged got %0b exp %0b", tag, converged, m_conv);
        end
        checks++;
        if (timeout !== m_tout) begin
            errors++;
            $display("FAIL %s timeout got %0b exp %0b", tag, timeout, m_tout);
        end
        checks++;
        if (iter_cnt !== 8'(m_iter)) begin
            errors++;
            $display("FAIL %s iter_cnt got %0d exp %0d", tag, iter_cnt, m_iter);
        end
`ifdef SYMM_CONV_ARGMAX_EN
        checks++;
        if (max_idx !== 4'(m_idx)) begin
            errors++;
            $display("FAIL %s max_idx got %0d exp %0d", tag, max_idx, m_idx);
        end
`endif
    endtask

    // Called at a negedge with d_arr loaded; returns in the done_conv cycle.
    task automatic run_check(input string tag);
        int mx, mi, cyc;
        bit seen;
        model_max(mx, mi);
        if (!m_conv && (m_iter + 1 >= TB_MAX_ITER) && (mx > TB_TOL)) m_tout = 1;
        if (mx <= TB_TOL) m_conv = 1;
        m_iter = (m_iter + 1 > TB_MAX_ITER) ? TB_MAX_ITER : m_iter + 1;
        m_max  = mx;
        m_idx  = mi;
        start_conv = 1'b1;
        @(negedge clk_conv);
        start_conv = 1'b0;
        scramble();
        checks++;
        if (busy_conv !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %0b exp 1", tag, busy_conv);
        end
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 40) begin
            if (done_conv === 1'b1) seen = 1;
            else begin
                @(negedge clk_conv);
                cyc++;
            end
        end
        checks++;
        if (!seen || cyc != 18) begin
            errors++;
            $display("FAIL %s latency got %0d seen %0b exp 18", tag, cyc, seen);
        end
        checks++;
        if (busy_conv !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done got %0b exp 0", tag, busy_conv);
        end
        check_outputs(tag);
    endtask

    task automatic do_clr();
        clr_conv = 1'b1;
        @(negedge clk_conv);
        clr_conv = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        m_max = 0;
        m_idx = 0;
        model_clear();
        checks++;
        if (busy_conv !== 1'b0 || done_conv !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/done got %0b/%0b exp 0/0", busy_conv, done_conv);
        end
        check_outputs("reset");
    endtask

    task automatic test_zero();
        fill_all(0);
        run_check("zero");
        @(negedge clk_conv);
        checks++;
        if (done_conv !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse done got %0b exp 0", done_conv);
        end
    endtask

    task automatic test_pattern();
        do_clr();
        fill_all(3);
        d_arr[6]  = 26'sd500;
        d_arr[12] = 26'sd1200;
        run_check("pattern");
        fill_all(3);
        d_arr[9] = -26'sd5000;
        d_arr[3] = 26'sd77;
        run_check("pattern2");
    endtask

    task automatic test_tol_boundary();
        do_clr();
        fill_all(0);
        d_arr[0] = 26'sd8;
        run_check("tol_eq");
        @(negedge clk_conv);
        do_clr();
        fill_all(0);
        d_arr[0] = 26'sd9;
        run_check("tol_above");
    endtask

    task automatic test_random();
        int mode, v, a, b;
        do_clr();
        for (int n = 0; n < 12; n++) begin
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                case (mode)
                    0: v = -1 - int'($urandom_range(0, 100000));
                    1: v = int'($urandom_range(0, 12));
                    default: v = int'($urandom_range(0, 60000)) - 30000;
                endcase
                d_arr[i] = 26'(v);
            end
            if (mode == 3) begin
                a = int'($urandom_range(0, 15));
                b = int'($urandom_range(0, 15));
                d_arr[a] = 26'sd40000;
                d_arr[b] = 26'sd40000;
            end
            if (n % 5 == 4) do_clr();
            run_check("random");
        end
    endtask

    task automatic test_timeout();
        do_clr();
        for (int n = 0; n < TB_MAX_ITER + 1; n++) begin
            fill_all(int'($urandom_range(0, 100)));
            d_arr[int'($urandom_range(0, 15))] = 26'sd100;
            run_check("timeout");
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int n = 0; n < 3; n++) begin
            fill_all(n * 7);
            run_check("back_to_back");
        end
    endtask

    task automatic test_clr_abort();
        int dones;
        do_clr();
        fill_all(1);
        d_arr[5] = 26'sd321;
        run_check("clr_prior");
        @(negedge clk_conv);
        fill_all(0);
        d_arr[2] = 26'sd9999;
        start_conv = 1'b1;
        @(negedge clk_conv);
        start_conv = 1'b0;
        repeat (5) @(negedge clk_conv);
        clr_conv   = 1'b1;
        start_conv = 1'b1;
        @(negedge clk_conv);
        clr_conv   = 1'b0;
        start_conv = 1'b0;
        model_clear();
        checks++;
        if (busy_conv !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort busy got %0b exp 0", busy_conv);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_conv);
            if (done_conv === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL clr_abort done_count got %0d exp 0", dones);
        end
        check_outputs("clr_abort");
    endtask

    task automatic test_restart_ignored();
        int dones, mx, mi;
        do_clr();
        fill_all(2);
        d_arr[11] = 26'sd4444;
        model_max(mx, mi);
        start_conv = 1'b1;
        @(negedge clk_conv);
        start_conv = 1'b0;
        fill_all(0);
        repeat (5) @(negedge clk_conv);
        d_arr[1] = 26'sd7777;
        start_conv = 1'b1;
        @(negedge clk_conv);
        start_conv = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_conv === 1'b1) dones++;
            @(negedge clk_conv);
        end
        m_iter = 1;
        m_conv = 0;
        m_max  = mx;
        m_idx  = mi;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL restart done_count got %0d exp 1", dones);
        end
        check_outputs("restart");
    endtask

    task automatic test_reset_midscan();
        fill_all(50);
        start_conv = 1'b1;
        @(negedge clk_conv);
        start_conv = 1'b0;
        repeat (5) @(negedge clk_conv);
        rstn_conv = 1'b0;
        #1;
        m_max = 0;
        m_idx = 0;
        model_clear();
        checks++;
        if (busy_conv !== 1'b0 || done_conv !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy/done got %0b/%0b exp 0/0", busy_conv, done_conv);
        end
        check_outputs("reset_mid");
        @(negedge clk_conv);
        rstn_conv = 1'b1;
        @(negedge clk_conv);
    endtask

    initial begin
        rstn_conv  = 1'b0;
        start_conv = 1'b0;
        clr_conv   = 1'b0;
        fill_all(0);
        repeat (2) @(negedge clk_conv);
        rstn_conv = 1'b1;
        test_reset();
        test_zero();
        test_pattern();
        @(negedge clk_conv);
        test_tol_boundary();
        @(negedge clk_conv);
        test_random();
        @(negedge clk_conv);
        test_timeout();
        @(negedge clk_conv);
        test_back_to_back();
        @(negedge clk_conv);
        test_clr_abort();
        test_restart_ignored();
        fill_all(0);
        d_arr[8] = 26'sd600;
        run_check("pre_reset");
        @(negedge clk_conv);
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/symm_conv_check.md
# symm_conv_check

Convergence detector for the FastICA symmetric-decorrelation loop, directly downstream of the |W·Wᵀ − I| element-magnitude stage. It snapshots the 16 Q13 deviation magnitudes, scans them serially for the maximum, and compares that maximum against a tolerance. It also counts iterations and flags convergence or timeout to the iteration controller.

## Interface
Parameters:
- TOL, 26'sd8, convergence tolerance in Q13 (8 ≈ 0.00098)
- MAX_ITER, 100, iteration limit (1..255)

Ports:
- clk_conv  in  1  clock, rising edge
- rstn_conv  in  1  asynchronous, active-low reset
- start_conv  in  1  one-cycle request to check the current deviation matrix
- clr_conv  in  1  synchronous clear of the iteration count and flags; aborts any scan
- d11..d44  in  26 each, signed  16 deviation magnitudes, Q13, row-major
- busy_conv  out  1  scan in progress
- done_conv  out  1  one-cycle pulse when results update
- max_dev  out  26 signed  largest deviation from the last completed check
- converged  out  1  max_dev ≤ TOL (sticky until clr_conv)
- timeout  out  1  iter_cnt reached MAX_ITER without convergence (sticky)
- iter_cnt  out  8  number of completed checks, saturating at MAX_ITER

## Operation
- States: IDLE, SCAN, DECIDE.
- **IDLE**
  - If start_conv = 1 and clr_conv = 0: latch d11..d44 into a 16-word snapshot, set run_max = 0 and idx = 0, then go to SCAN.
- **SCAN**
  - One element per cycle: if snap[idx] > run_max (signed compare), run_max ← snap[idx].
  - idx increments. After idx = 15 is processed, go to DECIDE.
  - Negative inputs never win, because run_max starts at 0.
- **DECIDE**
  - max_dev ← run_max.
  - converged ← converged | (run_max ≤ TOL).
  - iter_cnt ← min(iter_cnt+1, MAX_ITER).
  - timeout ← timeout | (iter_cnt+1 ≥ MAX_ITER && run_max > TOL).
  - Pulse done_conv, then return to IDLE.
- start_conv while busy_conv = 1 is ignored (not queued).
- clr_conv has priority over everything:
  - iter_cnt, converged and timeout go to 0; state goes to IDLE.
  - No done_conv for an aborted scan; max_dev is retained.
  - start_conv in the same cycle as clr_conv is ignored.
- Once converged = 1, further checks still update max_dev and iter_cnt; timeout cannot newly set.

## Timing
- Reset values: busy_conv 0, done_conv 0, max_dev 0, converged 0, timeout 0, iter_cnt 0, state IDLE.
- start_conv is sampled at edge k. Edges k+1..k+16 process idx 0..15. Edge k+17 (DECIDE) registers the results and done_conv.
- done_conv is high for the cycle after edge k+17. Latency is 17 cycles from start to results.
- busy_conv is high from edge k through edge k+17, and low in the done_conv cycle.
- A new start_conv is accepted in the done_conv cycle; the minimum restart period is 18 cycles.
- Inputs only need to be valid in the start_conv cycle.
- Reset asserted mid-scan returns immediately to the reset values.

## Configuration
- SYMM_CONV_ARGMAX_EN defined:
  - Adds output max_idx (4 bits, reset 0): the row-major index of the element that produced max_dev.
  - The first occurrence wins on ties (strict >).
  - If all elements are ≤ 0, max_idx = 0.
  - max_idx updates in DECIDE.
- SYMM_CONV_ARGMAX_EN not defined:
  - No max_idx port and no index register.
  - Everything else is unchanged.

## Structure
- Shared package symm_pkg holds:
  - FRAC_BITS = 13, Q13_ONE = 26'sd8192, DATA_W = 26;
  - the state enum (IDLE, SCAN, DECIDE);
  - ITER_W = 8.
- One sub-module, symm_max_cmp: a combinational signed compare-and-select of the current element against run_max, producing new_max and a take flag (used for max_idx).

## Test plan
- After reset, all inputs are 0. Pulse start → done_conv 17 cycles later, with max_dev = 0, converged = 1, iter_cnt = 1.
- d23 = 500, d41 = 1200, all others 3 → max_dev = 1200, converged = 0, iter_cnt increments; with ARGMAX, max_idx = 12.
- d11 = 8 (= TOL), rest 0 → converged = 1. With d11 = 9 → converged = 0 (boundary is inclusive).
- MAX_ITER = 3, every check has max_dev = 100 → timeout = 1 on the 3rd done; iter_cnt stays at 3 on a 4th check.
- clr_conv at scan cycle 5 → no done_conv, iter_cnt/converged/timeout = 0, max_dev keeps its prior value.
- start_conv re-pulsed mid-scan → ignored, with exactly one done_conv. Reset asserted mid-scan → all outputs 0 and busy_conv low.
